// File: rtl/dct_1d_fusion.sv
// 8-point 1-D DCT-II: Chen even/odd butterfly or caller-supplied 8x8 matrix,
// selected per transaction; one vector per clock, results three edges after start.
module dct_1d_fusion #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       mode_sel,
    input  logic [DATA_WIDTH-1:0]      x0,
    input  logic [DATA_WIDTH-1:0]      x1,
    input  logic [DATA_WIDTH-1:0]      x2,
    input  logic [DATA_WIDTH-1:0]      x3,
    input  logic [DATA_WIDTH-1:0]      x4,
    input  logic [DATA_WIDTH-1:0]      x5,
    input  logic [DATA_WIDTH-1:0]      x6,
    input  logic [DATA_WIDTH-1:0]      x7,
    input  logic [64*DATA_WIDTH-1:0]   coeff_vector,
    output logic [DATA_WIDTH-1:0]      y0,
    output logic [DATA_WIDTH-1:0]      y1,
    output logic [DATA_WIDTH-1:0]      y2,
    output logic [DATA_WIDTH-1:0]      y3,
    output logic [DATA_WIDTH-1:0]      y4,
    output logic [DATA_WIDTH-1:0]      y5,
    output logic [DATA_WIDTH-1:0]      y6,
    output logic [DATA_WIDTH-1:0]      y7,
    output logic                       valid
);

    // Accumulator is wide enough for eight full-scale products plus rounding.
    localparam int ACC_W = 2*DATA_WIDTH + 8;

    localparam logic signed [ACC_W-1:0] K_C1 = ACC_W'(8'sd126);
    localparam logic signed [ACC_W-1:0] K_C2 = ACC_W'(8'sd118);
    localparam logic signed [ACC_W-1:0] K_C3 = ACC_W'(8'sd106);
    localparam logic signed [ACC_W-1:0] K_C4 = ACC_W'(8'sd91);
    localparam logic signed [ACC_W-1:0] K_C5 = ACC_W'(8'sd71);
    localparam logic signed [ACC_W-1:0] K_C6 = ACC_W'(8'sd49);
    localparam logic signed [ACC_W-1:0] K_C7 = ACC_W'(8'sd25);
    localparam logic signed [ACC_W-1:0] RND_OFS = ACC_W'(9'sd128);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [DATA_WIDTH-1:0] x_r    [8];
    logic signed [DATA_WIDTH-1:0] coef_r [64];
    logic                         mode_r;
    logic                         v1_r, v2_r, v3_r, valid_r;
    logic signed [ACC_W-1:0]      a_s [4];
    logic signed [ACC_W-1:0]      b_s [4];
    logic signed [ACC_W-1:0]      chen_s [8];
    logic signed [ACC_W-1:0]      mat_s  [8];
    logic signed [ACC_W-1:0]      p_r    [8];
    logic [DATA_WIDTH-1:0]        s_r    [8];
    logic [DATA_WIDTH-1:0]        y_r    [8];

    // Round half-up by 2^8, then clamp to the signed output range.
    function automatic logic [DATA_WIDTH-1:0] round_sat(input logic signed [ACC_W-1:0] p);
        logic signed [ACC_W-1:0] r;
        r = (p + RND_OFS) >>> 4'd8;
        if (r > SAT_MAX) begin
            round_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (r < SAT_MIN) begin
            round_sat = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            round_sat = r[DATA_WIDTH-1:0];
        end
    endfunction

    // Stage 1: capture the transaction (samples, mode and the full matrix).
    always_ff @(posedge clk) begin
        if (reset_n) begin
            v1_r   <= 1'b0;
            mode_r <= 1'b0;
            for (int i = 0; i < 8; i++) x_r[i] <= {DATA_WIDTH{1'b0}};
            for (int i = 0; i < 64; i++) coef_r[i] <= {DATA_WIDTH{1'b0}};
        end else begin
            v1_r <= start;
            if (start) begin
                mode_r <= mode_sel;
                x_r[0] <= x0; x_r[1] <= x1; x_r[2] <= x2; x_r[3] <= x3;
                x_r[4] <= x4; x_r[5] <= x5; x_r[6] <= x6; x_r[7] <= x7;
                for (int i = 0; i < 64; i++)
                    coef_r[i] <= coeff_vector[(63-i)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                mode_r <= mode_r;
            end
        end
    end

    // Chen butterfly on the captured samples.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            a_s[n] = ACC_W'(x_r[n]) + ACC_W'(x_r[7-n]);
            b_s[n] = ACC_W'(x_r[n]) - ACC_W'(x_r[7-n]);
        end
        chen_s[0] = K_C4 * (a_s[0] + a_s[1] + a_s[2] + a_s[3]);
        chen_s[4] = K_C4 * (a_s[0] - a_s[1] - a_s[2] + a_s[3]);
        chen_s[2] = K_C2 * (a_s[0] - a_s[3]) + K_C6 * (a_s[1] - a_s[2]);
        chen_s[6] = K_C6 * (a_s[0] - a_s[3]) - K_C2 * (a_s[1] - a_s[2]);
        chen_s[1] = K_C1*b_s[0] + K_C3*b_s[1] + K_C5*b_s[2] + K_C7*b_s[3];
        chen_s[3] = K_C3*b_s[0] - K_C7*b_s[1] - K_C1*b_s[2] - K_C5*b_s[3];
        chen_s[5] = K_C5*b_s[0] - K_C1*b_s[1] + K_C7*b_s[2] + K_C3*b_s[3];
        chen_s[7] = K_C7*b_s[0] - K_C5*b_s[1] + K_C3*b_s[2] - K_C1*b_s[3];
    end

    // Generic matrix-vector product on the captured matrix.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            mat_s[k] = {ACC_W{1'b0}};
            for (int n = 0; n < 8; n++)
                mat_s[k] = mat_s[k] + ACC_W'(coef_r[8*k+n]) * ACC_W'(x_r[n]);
        end
    end

    // Stage 2: register the unscaled coefficients of the selected mode.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            v2_r <= 1'b0;
            for (int k = 0; k < 8; k++) p_r[k] <= {ACC_W{1'b0}};
        end else begin
            v2_r <= v1_r;
            for (int k = 0; k < 8; k++) p_r[k] <= mode_r ? mat_s[k] : chen_s[k];
        end
    end

    // Stage 3: rounding and saturation.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            v3_r <= 1'b0;
            for (int k = 0; k < 8; k++) s_r[k] <= {DATA_WIDTH{1'b0}};
        end else begin
            v3_r <= v2_r;
            for (int k = 0; k < 8; k++) s_r[k] <= round_sat(p_r[k]);
        end
    end

    // Output register: loads only on a completed transaction, otherwise holds.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            valid_r <= 1'b0;
            for (int k = 0; k < 8; k++) y_r[k] <= {DATA_WIDTH{1'b0}};
        end else begin
            valid_r <= v3_r;
            if (v3_r) begin
                for (int k = 0; k < 8; k++) y_r[k] <= s_r[k];
            end else begin
                for (int k = 0; k < 8; k++) y_r[k] <= y_r[k];
            end
        end
    end

    assign valid = valid_r;
    assign y0 = y_r[0]; assign y1 = y_r[1]; assign y2 = y_r[2]; assign y3 = y_r[3];
    assign y4 = y_r[4]; assign y5 = y_r[5]; assign y6 = y_r[6]; assign y7 = y_r[7];

endmodule

// File: tb/tb_dct_1d_fusion.sv
// Table-driven bench for dct_1d_fusion: a scoreboard queue gets each expected
// result when start is driven; a negedge monitor pops and checks on every valid.
module tb_dct_1d_fusion;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n, start, mode_sel;
    logic [7:0][DW-1:0] xv;
    logic [63:0][DW-1:0] cv;
    logic [DW-1:0]      y0, y1, y2, y3, y4, y5, y6, y7;
    logic               valid;
    logic [7:0][DW-1:0] yd;

    assign yd = {y7, y6, y5, y4, y3, y2, y1, y0};

    dct_1d_fusion #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode_sel(mode_sel),
        .x0(xv[0]), .x1(xv[1]), .x2(xv[2]), .x3(xv[3]),
        .x4(xv[4]), .x5(xv[5]), .x6(xv[6]), .x7(xv[7]),
        .coeff_vector(cv),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
        .valid(valid)
    );

    typedef struct {
        string               name;
        logic                mode;
        logic [7:0][DW-1:0]  x;
        logic [63:0][DW-1:0] c;
        logic [7:0][DW-1:0]  y;
    } vec_t;

    typedef struct {
        string              name;
        logic [7:0][DW-1:0] y;
        int                 due;
    } exp_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    logic   mon_en  = 1'b0;
    exp_t   sb[$];
    exp_t   cur;
    vec_t   tbl[9];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0][DW-1:0] v8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [7:0][DW-1:0] r;
        r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
        r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
        return r;
    endfunction

    function automatic logic [63:0][DW-1:0] junk_mat();
        logic [63:0][DW-1:0] c;
        for (int i = 0; i < 64; i++) c[i] = 16'($urandom);
        return c;
    endfunction

    // Row 0 all 100, row 1 a cosine-like row, rows 2..7 pass x_k through (256 on the diagonal).
    function automatic logic [63:0][DW-1:0] ramp_mat();
        logic [63:0][DW-1:0] c;
        int r1[8];
        r1 = '{138, 117, 50, -50, -117, -138, -92, -20};
        for (int i = 0; i < 64; i++) c[i] = 16'd0;
        for (int n = 0; n < 8; n++) begin
            c[63-n]     = 16'd100;
            c[63-(8+n)] = 16'(r1[n]);
        end
        for (int k = 2; k < 8; k++) c[63-(9*k)] = 16'd256;
        return c;
    endfunction

    function automatic logic [63:0][DW-1:0] full_mat();
        logic [63:0][DW-1:0] c;
        for (int i = 0; i < 64; i++) c[i] = 16'h7fff;
        return c;
    endfunction

    // Monitor: every valid pulse must match the oldest pending result at the right cycle.
    always @(negedge clk) begin
        if (mon_en && valid === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got valid=1 y=%h, required no pending result", yd);
            end else begin
                cur = sb.pop_front();
                if (yd !== cur.y) begin
                    n_fail++;
                    $display("FAIL %s result: got y=%h, required %h", cur.name, yd, cur.y);
                end
                n_tests++;
                if (cyc != cur.due) begin
                    n_fail++;
                    $display("FAIL %s latency: got pulse at cycle %0d, required %0d", cur.name, cyc, cur.due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        start    = 1'b0;
        mode_sel = 1'($urandom);
        for (int i = 0; i < 8; i++) xv[i] = 16'($urandom);
        cv = junk_mat();
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        start    = 1'b1;
        mode_sel = v.mode;
        xv       = v.x;
        cv       = v.c;
        e.name   = v.name;
        e.y      = v.y;
        e.due    = cyc + 4;
        sb.push_back(e);
        tick();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s timeout: %0d results still pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_hold(input string name, input logic [7:0][DW-1:0] exp_y);
        @(negedge clk);
        n_tests++;
        if (valid !== 1'b0 || yd !== exp_y) begin
            n_fail++;
            $display("FAIL %s hold: got valid=%b y=%h, required valid=0 y=%h", name, valid, yd, exp_y);
        end
    endtask

    task automatic check_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            n_tests++;
            if (valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s quiet: got valid=%b, required 0", name, valid);
            end
        end
    endtask

    initial begin
        tbl[0] = '{"chen_ramp",    1'b0, v8(10,20,30,40,50,60,70,80),  junk_mat(), v8(128,-64,0,-7,0,-2,0,0)};
        tbl[1] = '{"mat_ramp",     1'b1, v8(10,20,30,40,50,60,70,80),  ramp_mat(), v8(141,-74,30,40,50,60,70,80)};
        tbl[2] = '{"chen_impulse", 1'b0, v8(100,0,0,0,0,0,0,0),        junk_mat(), v8(36,49,46,41,36,28,19,10)};
        tbl[3] = '{"chen_zero",    1'b0, v8(0,0,0,0,0,0,0,0),          junk_mat(), v8(0,0,0,0,0,0,0,0)};
        tbl[4] = '{"mat_zero",     1'b1, v8(0,0,0,0,0,0,0,0),          ramp_mat(), v8(0,0,0,0,0,0,0,0)};
        tbl[5] = '{"mat_sat_pos",  1'b1, v8(32767,32767,32767,32767,32767,32767,32767,32767), full_mat(),
                   v8(32767,32767,32767,32767,32767,32767,32767,32767)};
        tbl[6] = '{"mat_sat_neg",  1'b1, v8(-32767,-32767,-32767,-32767,-32767,-32767,-32767,-32767), full_mat(),
                   v8(-32768,-32768,-32768,-32768,-32768,-32768,-32768,-32768)};
        tbl[7] = '{"chen_sat_pos", 1'b0, v8(32767,32767,32767,32767,32767,32767,32767,32767), junk_mat(),
                   v8(32767,0,0,0,0,0,0,0)};
        tbl[8] = '{"chen_sat_neg", 1'b0, v8(-32768,-32768,-32768,-32768,-32768,-32768,-32768,-32768), junk_mat(),
                   v8(-32768,0,0,0,0,0,0,0)};

        // Reset held for two edges with start high: nothing may come out.
        reset_n  = 1'b1;
        start    = 1'b1;
        mode_sel = 1'b0;
        xv       = tbl[0].x;
        cv       = junk_mat();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (valid !== 1'b0 || yd !== v8(0,0,0,0,0,0,0,0)) begin
                n_fail++;
                $display("FAIL reset_state: got valid=%b y=%h, required valid=0 y=0", valid, yd);
            end
        end
        reset_n = 1'b0;
        start   = 1'b0;
        mon_en  = 1'b1;
        check_quiet("post_reset", 6);

        // Single-shot vectors, each followed by a hold check.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i]);
            scramble();
            drain(tbl[i].name);
            check_hold(tbl[i].name, tbl[i].y);
        end

        // Back-to-back mixed modes; matrix changes under the in-flight transaction.
        drive(tbl[0]);
        drive(tbl[1]);
        drive(tbl[2]);
        scramble();
        drain("b2b");
        check_hold("b2b", tbl[2].y);

        // Reset with two transactions in flight: both must be discarded.
        drive(tbl[1]);
        drive(tbl[5]);
        sb.delete();
        start   = 1'b0;
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        n_tests++;
        if (yd !== v8(0,0,0,0,0,0,0,0)) begin
            n_fail++;
            $display("FAIL midstream_reset outputs: got y=%h, required 0", yd);
        end
        check_quiet("midstream_reset", 8);

        // Recovery after the mid-stream reset.
        drive(tbl[2]);
        scramble();
        drain("recovery");
        check_hold("recovery", tbl[2].y);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dct_1d_fusion.md
Name: dct_1d_fusion

Overview:
- 8-point 1-D DCT-II engine for the image-compression datapath. Works on one row or column of an 8x8 block per transaction.
- Two computation modes, chosen per transaction:
  - mode_sel=0: Chen-style even/odd butterfly with fixed internal constants.
  - mode_sel=1: generic 8x8 matrix-vector multiply using a caller-supplied coefficient matrix.
- Fully pipelined: accepts one vector per clock, fixed latency.

Parameters:
DATA_WIDTH, 16, width of each input sample, coefficient and output; all are two's-complement signed.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous, active-high reset; the block resets when reset_n=1 at a clk edge
start  input  1  qualifies x0..x7, mode_sel and coeff_vector at this edge
mode_sel  input  1  0 = Chen butterfly, 1 = matrix multiply
x0..x7  input  DATA_WIDTH each  signed input samples, x0 = n=0
coeff_vector  input  64*DATA_WIDTH  signed matrix C[k][n]; C[0][0] in bits [1023:1008], row-major, C[7][7] in bits [15:0]
y0..y7  output  DATA_WIDTH each  signed DCT coefficients, y0 = DC
valid  output  1  one-cycle pulse: y0..y7 hold a new result

Behaviour:
- Reset (reset_n=1 at an edge):
  - y0..y7 = 0, valid = 0.
  - All pipeline stage-valid bits are cleared; in-flight transactions are discarded and never produce valid.
- Latency and pipeline:
  - start is sampled at edge N. At that edge, x, mode_sel and coeff_vector are captured.
  - y0..y7 and valid update at edge N+3, so valid is high during cycle N+3 to N+4.
  - start may be high on consecutive edges; each start produces exactly one valid pulse, in order.
  - The mode is carried per transaction, so mixed-mode back-to-back starts are legal.
- Between results, y0..y7 hold their last value and valid=0. Inputs are don't-care when start=0.
- Chen mode (mode_sel=0), Q8 constants with the 1/2 DCT-II scale folded in:
  - C1=126, C2=118, C3=106, C4=91, C5=71, C6=49, C7=25.
  - Butterfly terms: a_n = x_n + x_(7-n), b_n = x_n - x_(7-n), for n = 0..3.
  - P0 = C4*(a0+a1+a2+a3); P4 = C4*(a0-a1-a2+a3).
  - P2 = C2*(a0-a3) + C6*(a1-a2); P6 = C6*(a0-a3) - C2*(a1-a2).
  - P1 = C1*b0 + C3*b1 + C5*b2 + C7*b3; P3 = C3*b0 - C7*b1 - C1*b2 - C5*b3.
  - P5 = C5*b0 - C1*b1 + C7*b2 + C3*b3; P7 = C7*b0 - C5*b1 + C3*b2 - C1*b3.
- Matrix mode (mode_sel=1): P_k = sum over n of C[k][n]*x_n, with signed products.
- Output scaling, both modes:
  - y_k = sat16((P_k + 128) >>> 8), i.e. arithmetic shift with round-half-up.
  - Saturate to [-32768, 32767].
  - Intermediates use at least 36-bit signed width, so there is no internal overflow before saturation.
- Boundary cases:
  - All-zero input gives all-zero output.
  - Full-scale inputs saturate and do not wrap.
  - The coefficient matrix is captured with start; changing coeff_vector later does not affect an in-flight result.

Test Plan:
- Reset: assert reset_n=1 for 2 cycles with start=1 -> valid stays 0 and y0..y7=0; release; no spurious valid.
- Chen ramp: x=10,20,...,80, mode 0, single start -> 3 cycles later one valid pulse with y=128,-64,0,-7,0,-2,0,0; outputs held after the pulse.
- Matrix ramp: same x, mode 1, coeff rows {100 x8} and {138,117,50,-50,-117,-138,-92,-20} -> y0=141, y1=-74; rows 2..7 per the formula.
- Chen impulse: x=100,0,...,0, mode 0 -> y=36,49,46,41,36,28,19,10.
- Back-to-back: starts on 3 consecutive edges, modes 0/1/0 -> 3 consecutive valid pulses in order, each matching its single-shot result; a reset mid-stream kills the pending pulses.
- Saturation: mode 1, all C=32767 and all x=32767 -> y0..y7=32767; negate x -> -32768.
